// File: rtl/umem_cmd_ctrl.sv
// Host command sequencer between the UART byte stream and the memory's UART-side port.
// Decodes W/R/D/G byte commands, hands memory to the CPU for a run and reports back over tx.
module umem_cmd_ctrl #(
  parameter int MEM_BYTE_ADDR_WIDTH = 6
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           rx_valid,
  input  logic [7:0]                     rx_data,
  output logic                           tx_valid,
  output logic [7:0]                     tx_data,
  input  logic                           tx_ready,
  output logic                           umem_ctrl,
  output logic                           umem_rd_en,
  output logic                           umem_wr_en,
  output logic [MEM_BYTE_ADDR_WIDTH-1:0] umem_addr,
  output logic [7:0]                     umem_wr_data,
  input  logic [7:0]                     umem_rd_data,
  output logic                           cpu_run,
  input  logic                           cpu_halt,
  output logic                           rx_overrun
);

  localparam logic [7:0] CMD_W    = 8'h57;
  localparam logic [7:0] CMD_R    = 8'h52;
  localparam logic [7:0] CMD_D    = 8'h44;
  localparam logic [7:0] CMD_G    = 8'h47;
  localparam logic [7:0] ERR_BYTE = 8'h3F;
  localparam logic [7:0] ACK_BYTE = 8'h4B;
  localparam logic [MEM_BYTE_ADDR_WIDTH-1:0] ADDR_LAST = '1;

  typedef enum logic [3:0] {
    IDLE, GET_ADDR, GET_DATA, WRITE, READ, SEND, DUMP_RD, DUMP_SEND, RUN
  } state_t;

  state_t state, state_next;
  logic   cmd_write;
  logic   accepting;
  logic   is_known_cmd;

  assign is_known_cmd = (rx_data == CMD_W) || (rx_data == CMD_R) ||
                        (rx_data == CMD_D) || (rx_data == CMD_G);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Strobes, tx_valid and memory ownership are pure decodes of the current state.
  always_comb begin
    state_next = state;
    tx_valid   = 1'b0;
    umem_rd_en = 1'b0;
    umem_wr_en = 1'b0;
    cpu_run    = 1'b0;
    umem_ctrl  = 1'b1;
    accepting  = 1'b0;
    case (state)
      IDLE: begin
        accepting = 1'b1;
        if (rx_valid) begin
          case (rx_data)
            CMD_W, CMD_R: state_next = GET_ADDR;
            CMD_D:        state_next = DUMP_RD;
            CMD_G:        state_next = RUN;
            default:      state_next = SEND;
          endcase
        end
      end
      GET_ADDR: begin
        accepting = 1'b1;
        if (rx_valid) state_next = cmd_write ? GET_DATA : READ;
      end
      GET_DATA: begin
        accepting = 1'b1;
        if (rx_valid) state_next = WRITE;
      end
      WRITE: begin
        umem_wr_en = 1'b1;
        state_next = IDLE;
      end
      READ: begin
        umem_rd_en = 1'b1;
        state_next = SEND;
      end
      SEND: begin
        tx_valid = 1'b1;
        if (tx_ready) state_next = IDLE;
      end
      DUMP_RD: begin
        umem_rd_en = 1'b1;
        state_next = DUMP_SEND;
      end
      DUMP_SEND: begin
        tx_valid = 1'b1;
        if (tx_ready) state_next = (umem_addr == ADDR_LAST) ? IDLE : DUMP_RD;
      end
      RUN: begin
        cpu_run   = 1'b1;
        umem_ctrl = 1'b0;
        if (cpu_halt) state_next = SEND;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath registers; the dump address increment wraps to zero after the last byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_write    <= 1'b0;
      umem_addr    <= '0;
      umem_wr_data <= 8'h00;
      tx_data      <= 8'h00;
      rx_overrun   <= 1'b0;
    end else begin
      if (rx_valid && !accepting) rx_overrun <= 1'b1;
      case (state)
        IDLE: begin
          if (rx_valid) begin
            cmd_write <= (rx_data == CMD_W);
            if (rx_data == CMD_D)  umem_addr <= '0;
            else if (!is_known_cmd) tx_data  <= ERR_BYTE;
          end
        end
        GET_ADDR:  if (rx_valid) umem_addr <= rx_data[MEM_BYTE_ADDR_WIDTH-1:0];
        GET_DATA:  if (rx_valid) umem_wr_data <= rx_data;
        READ:      tx_data <= umem_rd_data;
        DUMP_RD:   tx_data <= umem_rd_data;
        DUMP_SEND: if (tx_ready) umem_addr <= umem_addr + 1'b1;
        RUN:       if (cpu_halt) tx_data <= ACK_BYTE;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_umem_cmd_ctrl.sv
// Self-checking bench for umem_cmd_ctrl: vector table, hand-written corner sequences and
// randomized commands checked against a byte-level model of the host protocol and memory.
module tb_umem_cmd_ctrl;

  localparam int AW = 6;
  localparam int NB = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          rx_valid;
  logic [7:0]    rx_data;
  logic          tx_valid;
  logic [7:0]    tx_data;
  logic          tx_ready = 1'b0;
  logic          umem_ctrl;
  logic          umem_rd_en;
  logic          umem_wr_en;
  logic [AW-1:0] umem_addr;
  logic [7:0]    umem_wr_data;
  logic [7:0]    umem_rd_data;
  logic          cpu_run;
  logic          cpu_halt;
  logic          rx_overrun;

  always #5 clk = ~clk;

  umem_cmd_ctrl #(.MEM_BYTE_ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .umem_ctrl(umem_ctrl), .umem_rd_en(umem_rd_en), .umem_wr_en(umem_wr_en),
    .umem_addr(umem_addr), .umem_wr_data(umem_wr_data), .umem_rd_data(umem_rd_data),
    .cpu_run(cpu_run), .cpu_halt(cpu_halt), .rx_overrun(rx_overrun)
  );

  // Physical memory, written only by the DUT's strobes; model_mem holds what the host intended.
  logic [7:0]  mem [NB];
  logic [7:0]  model_mem [NB];
  assign umem_rd_data = mem[umem_addr];

  logic [7:0]  tx_q [$];
  logic [15:0] wr_log [$];
  int          rd_count = 0;
  int          viol = 0;
  int          stab_err = 0;
  int          checks = 0;
  int          errors = 0;
  bit          bp_random = 1'b0;
  logic        ready_force = 1'b1;
  logic        prev_pend = 1'b0;
  logic [7:0]  prev_data = 8'h00;

  always @(negedge clk) begin
    if (umem_wr_en) begin
      mem[umem_addr] = umem_wr_data;
      wr_log.push_back({8'(umem_addr), umem_wr_data});
    end
    if (umem_rd_en) rd_count++;
    if (tx_valid && tx_ready) tx_q.push_back(tx_data);
    if (prev_pend && (!tx_valid || tx_data !== prev_data)) stab_err++;
    prev_pend = tx_valid && !tx_ready && !rst;
    prev_data = tx_data;
    if ((umem_rd_en && umem_wr_en) || ((umem_rd_en || umem_wr_en) && !umem_ctrl)) viol++;
  end

  always begin
    @(posedge clk);
    #2;
    tx_ready = bp_random ? 1'($urandom_range(0, 1)) : ready_force;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got still running, expected finished");
    $fatal(1, "[TB] watchdog expired");
  end

  typedef struct {
    int            n;
    logic [7:0]    b0, b1, b2;
    bit            has_tx;
    logic [7:0]    exp_tx;
    bit            has_wr;
    logic [AW-1:0] exp_addr;
    logic [7:0]    exp_data;
  } vec_t;

  vec_t vecs [8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic wait_tx(input int target, input int budget);
    int c = 0;
    while (tx_q.size() < target && c < budget) begin
      tick();
      c++;
    end
    if (tx_q.size() < target) checkOutput("tx_timeout", tx_q.size(), target);
  endtask

  task automatic write_cmd(input logic [7:0] a, input logic [7:0] d);
    send_byte(8'h57);
    send_byte(a);
    send_byte(d);
    tick();
    model_mem[a % NB] = d;
  endtask

  task automatic expect_tx(input string name, input logic [7:0] cmd, input logic [7:0] exp);
    int base = tx_q.size();
    send_byte(cmd);
    wait_tx(base + 1, 200);
    if (tx_q.size() > base) checkOutput(name, tx_q[base], exp);
  endtask

  task automatic read_cmd(input string name, input logic [7:0] a);
    int base = tx_q.size();
    send_byte(8'h52);
    send_byte(a);
    wait_tx(base + 1, 200);
    if (tx_q.size() > base) checkOutput(name, tx_q[base], model_mem[a % NB]);
  endtask

  task automatic dump_check(input string name);
    int base = tx_q.size();
    send_byte(8'h44);
    wait_tx(base + NB, 4000);
    for (int i = 0; i < NB; i++)
      if (tx_q.size() > base + i) checkOutput($sformatf("%s[%0d]", name, i), tx_q[base + i], model_mem[i]);
    checkOutput({name, "_end_addr"}, umem_addr, 0);
    checkOutput({name, "_end_txv"}, tx_valid, 0);
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    int tb = tx_q.size();
    int wb = wr_log.size();
    send_byte(v.b0);
    if (v.n > 1) send_byte(v.b1);
    if (v.n > 2) send_byte(v.b2);
    if (v.has_tx) wait_tx(tb + 1, 50);
    else repeat (3) tick();
    checkOutput($sformatf("vec%0d_wr_count", idx), wr_log.size() - wb, v.has_wr ? 1 : 0);
    if (v.has_wr && wr_log.size() > wb) begin
      checkOutput($sformatf("vec%0d_wr", idx), wr_log[wb], {8'(v.exp_addr), v.exp_data});
      model_mem[v.exp_addr] = v.exp_data;
    end
    checkOutput($sformatf("vec%0d_tx_count", idx), tx_q.size() - tb, v.has_tx ? 1 : 0);
    if (v.has_tx && tx_q.size() > tb)
      checkOutput($sformatf("vec%0d_tx", idx), tx_q[tb], v.exp_tx);
  endtask

  initial begin
    int base;
    logic [7:0] a, d, b;

    vecs[0] = '{3, 8'h57, 8'h05, 8'hA5, 1'b0, 8'h00, 1'b1, 6'd5,  8'hA5};
    vecs[1] = '{2, 8'h52, 8'hC5, 8'h00, 1'b1, 8'hA5, 1'b0, 6'd0,  8'h00};
    vecs[2] = '{1, 8'h7A, 8'h00, 8'h00, 1'b1, 8'h3F, 1'b0, 6'd0,  8'h00};
    vecs[3] = '{3, 8'h57, 8'hFF, 8'h11, 1'b0, 8'h00, 1'b1, 6'd63, 8'h11};
    vecs[4] = '{2, 8'h52, 8'h3F, 8'h00, 1'b1, 8'h11, 1'b0, 6'd0,  8'h00};
    vecs[5] = '{3, 8'h57, 8'h40, 8'h5A, 1'b0, 8'h00, 1'b1, 6'd0,  8'h5A};
    vecs[6] = '{2, 8'h52, 8'h80, 8'h00, 1'b1, 8'h5A, 1'b0, 6'd0,  8'h00};
    vecs[7] = '{1, 8'h00, 8'h00, 8'h00, 1'b1, 8'h3F, 1'b0, 6'd0,  8'h00};

    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; cpu_halt = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    checkOutput("rst_tx_valid", tx_valid, 0);
    checkOutput("rst_tx_data", tx_data, 0);
    checkOutput("rst_umem_ctrl", umem_ctrl, 1);
    checkOutput("rst_cpu_run", cpu_run, 0);
    checkOutput("rst_rd_en", umem_rd_en, 0);
    checkOutput("rst_wr_en", umem_wr_en, 0);
    checkOutput("rst_addr", umem_addr, 0);
    checkOutput("rst_wr_data", umem_wr_data, 0);
    checkOutput("rst_overrun", rx_overrun, 0);

    $display("[TB] write strobe latency");
    send_byte(8'h57); send_byte(8'h21); send_byte(8'h3C);
    checkOutput("w_strobe", umem_wr_en, 1);
    checkOutput("w_addr", umem_addr, 6'h21);
    checkOutput("w_data", umem_wr_data, 8'h3C);
    checkOutput("w_ctrl", umem_ctrl, 1);
    tick();
    checkOutput("w_strobe_one_cycle", umem_wr_en, 0);
    model_mem[6'h21] = 8'h3C;

    $display("[TB] vector table");
    for (int i = 0; i < 8; i++) applyStimulus(vecs[i], i);

    $display("[TB] read with tx backpressure");
    ready_force = 1'b0;
    base = rd_count;
    send_byte(8'h52); send_byte(8'hC5);
    checkOutput("r_rd_en", umem_rd_en, 1);
    checkOutput("r_addr", umem_addr, 5);
    tick();
    checkOutput("r_tx_valid", tx_valid, 1);
    checkOutput("r_tx_data", tx_data, 8'hA5);
    for (int i = 0; i < 7; i++) begin
      tick();
      checkOutput($sformatf("r_hold%0d", i), {tx_valid, tx_data}, {1'b1, 8'hA5});
    end
    ready_force = 1'b1;
    tick();
    checkOutput("r_tx_drop", tx_valid, 0);
    checkOutput("r_rd_count", rd_count - base, 1);

    $display("[TB] preload and dump");
    for (int i = 0; i < NB; i++) write_cmd(8'(i), 8'(i) ^ 8'h3C);
    bp_random = 1'b1;
    dump_check("dump1");
    bp_random = 1'b0;

    $display("[TB] run and halt");
    send_byte(8'h47);
    checkOutput("g_run", {cpu_run, umem_ctrl}, 2'b10);
    repeat (20) tick();
    checkOutput("g_run_held", {cpu_run, umem_ctrl}, 2'b10);
    cpu_halt = 1'b1;
    tick();
    cpu_halt = 1'b0;
    checkOutput("g_after_halt", {cpu_run, umem_ctrl, tx_valid}, 3'b011);
    checkOutput("g_ack", tx_data, 8'h4B);
    tick();

    cpu_halt = 1'b1;
    tick();
    checkOutput("halt_outside_run", {tx_valid, cpu_run}, 2'b00);
    send_byte(8'h47);
    checkOutput("g2_first_run", cpu_run, 1);
    tick();
    cpu_halt = 1'b0;
    checkOutput("g2_one_cycle", {cpu_run, umem_ctrl, tx_valid}, 3'b011);
    checkOutput("g2_ack", tx_data, 8'h4B);
    tick();

    $display("[TB] stray byte during send");
    ready_force = 1'b0;
    checkOutput("ovr_clear", rx_overrun, 0);
    send_byte(8'h52); send_byte(8'h05);
    tick();
    send_byte(8'h99);
    checkOutput("ovr_set", rx_overrun, 1);
    checkOutput("ovr_tx", {tx_valid, tx_data}, {1'b1, model_mem[5]});
    ready_force = 1'b1;
    tick();
    checkOutput("ovr_tx_drop", tx_valid, 0);
    checkOutput("ovr_sticky", rx_overrun, 1);

    $display("[TB] randomized commands");
    bp_random = 1'b1;
    for (int k = 0; k < 40; k++) begin
      repeat ($urandom_range(0, 2)) tick();
      a = 8'($urandom); d = 8'($urandom);
      case ($urandom_range(0, 7))
        0, 1, 2: write_cmd(a, d);
        3, 4, 5: read_cmd($sformatf("rand%0d_read", k), a);
        6: begin
          b = 8'($urandom);
          if (b == 8'h57 || b == 8'h52 || b == 8'h44 || b == 8'h47) b = b ^ 8'h80;
          expect_tx($sformatf("rand%0d_err", k), b, 8'h3F);
        end
        default: begin
          base = tx_q.size();
          send_byte(8'h47);
          repeat ($urandom_range(0, 10)) tick();
          checkOutput($sformatf("rand%0d_run", k), {cpu_run, umem_ctrl}, 2'b10);
          cpu_halt = 1'b1;
          tick();
          cpu_halt = 1'b0;
          wait_tx(base + 1, 200);
          if (tx_q.size() > base) checkOutput($sformatf("rand%0d_ack", k), tx_q[base], 8'h4B);
        end
      endcase
    end
    dump_check("dump2");
    bp_random = 1'b0;

    $display("[TB] reset during run and send");
    ready_force = 1'b0;
    send_byte(8'h47);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("rst_run", {tx_valid, cpu_run, umem_ctrl, rx_overrun}, 4'b0010);
    send_byte(8'h7A);
    repeat (2) tick();
    checkOutput("pre_rst_send", tx_valid, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("rst_send", {tx_valid, cpu_run, umem_ctrl, rx_overrun}, 4'b0010);
    checkOutput("rst_send_data", tx_data, 0);
    ready_force = 1'b1;
    base = wr_log.size();
    write_cmd(8'h0A, 8'h77);
    checkOutput("post_rst_wr_count", wr_log.size() - base, 1);
    if (wr_log.size() > base) checkOutput("post_rst_wr", wr_log[base], 16'h0A77);
    read_cmd("post_rst_read", 8'h0A);

    checkOutput("rd_wr_exclusive", viol, 0);
    checkOutput("tx_hold_stable", stab_err, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/umem_cmd_ctrl.md
Name: umem_cmd_ctrl

Overview:
- Command sequencer between the UART byte receiver/transmitter and the memory register file's UART-side port.
- Parses host byte commands (write byte, read byte, dump, run) and drives the memory's UART port strobes.
- Owns the memory-ownership select: UART-side vs CPU-side.
- Starts the CPU, waits for its halt, reclaims memory and acknowledges the host.

Parameters:
- MEM_BYTE_ADDR_WIDTH, 6, byte-address width of the memory; 2**MEM_BYTE_ADDR_WIDTH bytes.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- rx_valid  in  1  one-cycle pulse, received byte valid
- rx_data  in  8  received byte
- tx_valid  out  1  byte offered to the transmitter
- tx_data  out  8  byte to transmit
- tx_ready  in  1  transmitter accepts tx_data this cycle when tx_valid=1
- umem_ctrl  out  1  1 = UART port owns memory; 0 = CPU owns it
- umem_rd_en  out  1  memory read strobe
- umem_wr_en  out  1  memory write strobe
- umem_addr  out  MEM_BYTE_ADDR_WIDTH  memory byte address
- umem_wr_data  out  8  memory write data
- umem_rd_data  in  8  memory read data, combinational from umem_addr
- cpu_run  out  1  CPU enable
- cpu_halt  in  1  CPU finished (level or pulse, sampled only in RUN)
- rx_overrun  out  1  sticky: byte arrived while not accepting

Behaviour:
- Reset values: state=IDLE; umem_ctrl=1; cpu_run=0; tx_valid=0; tx_data=0; umem_rd_en=0; umem_wr_en=0; umem_addr=0; umem_wr_data=0; rx_overrun=0.
- Reset mid-operation aborts everything in the same edge, including a pending tx byte and RUN.
- Command bytes:
  - 0x57 'W': expects addr, then data.
  - 0x52 'R': expects addr.
  - 0x44 'D': dump.
  - 0x47 'G': go.
  - Any other byte: error.
- Address bytes use rx_data[MEM_BYTE_ADDR_WIDTH-1:0]; upper bits are ignored.
- States and transitions:
  - IDLE: on rx_valid, decode the byte.
    - W or R -> GET_ADDR, command latched.
    - D -> DUMP_RD, addr=0.
    - G -> RUN.
    - Other -> SEND with tx_data=0x3F.
  - GET_ADDR: on rx_valid, latch umem_addr. Next state: W -> GET_DATA; R -> READ.
  - GET_DATA: on rx_valid, latch umem_wr_data -> WRITE.
  - WRITE: umem_wr_en=1 for exactly one cycle -> IDLE. No acknowledge byte is sent.
  - READ: umem_rd_en=1 for one cycle; tx_data<=umem_rd_data at the end of that cycle -> SEND.
  - SEND: tx_valid=1 and tx_data held stable until tx_ready=1, then tx_valid=0 next cycle -> IDLE.
  - DUMP_RD: one-cycle umem_rd_en; tx_data<=umem_rd_data -> DUMP_SEND.
  - DUMP_SEND: hold tx_valid until tx_ready.
    - If umem_addr is all-ones -> IDLE; umem_addr wraps to 0.
    - Else umem_addr+1 -> DUMP_RD.
  - RUN: umem_ctrl=0, cpu_run=1 from the first RUN cycle. On cpu_halt=1: cpu_run=0 and umem_ctrl=1 next cycle, tx_data=0x4B -> SEND.
- Latency:
  - 'W' write strobe occurs 1 cycle after the data byte is accepted.
  - 'R' tx_valid rises 2 cycles after the addr byte is accepted.
  - Dump emits exactly 2**MEM_BYTE_ADDR_WIDTH bytes, ascending from 0.
- umem_rd_en and umem_wr_en are never asserted together, and never while umem_ctrl=0.
- rx_valid in any state other than IDLE/GET_ADDR/GET_DATA: the byte is dropped, rx_overrun sets, and the state is unaffected. rx_overrun clears only on reset.
- tx_ready while tx_valid=0 is ignored.
- cpu_halt outside RUN is ignored.
- cpu_halt already high on RUN entry: RUN lasts one cycle.
- No command timeout; a partial command waits indefinitely.

Test Plan:
- Reset, then send 0x57,0x05,0xA5 -> one umem_wr_en pulse with umem_addr=5, umem_wr_data=0xA5, umem_ctrl=1 throughout; no tx byte.
- Model memory with addr 5 = 0xA5; send 0x52,0xC5 (addr masks to 5) -> one umem_rd_en with umem_addr=5, tx_valid with tx_data=0xA5. Hold tx_ready=0 for 7 cycles -> tx_data stable; then tx_ready=1 -> tx_valid drops next cycle.
- Memory preloaded with byte[i]=i^0x3C, send 0x44 with random tx_ready backpressure -> 64 bytes 0x3C,0x3D,... in address order; ends in IDLE with umem_addr=0.
- Send 0x47 -> umem_ctrl=0 and cpu_run=1. Pulse cpu_halt after 20 cycles -> cpu_run=0, umem_ctrl=1, tx byte 0x4B.
- Send 0x7A -> tx byte 0x3F. Send 0x52 then a stray rx byte during SEND -> rx_overrun=1, read result still correct.
- Assert rst during RUN and during SEND with tx_ready=0 -> next cycle tx_valid=0, cpu_run=0, umem_ctrl=1, rx_overrun=0; a following 'W' command works.
